// File: rtl/pmp_csr_regfile_pkg.sv
// Shared types and constants for the PMP CSR register file: CSR addresses,
// cfg byte layout, A-field encodings and the WARL legalisation of a cfg byte.
package pmp_csr_regfile_pkg;

  localparam logic [11:0] PMPCFG0  = 12'h3A0;
  localparam logic [11:0] PMPADDR0 = 12'h3B0;

  localparam int CFG_R_BIT  = 0;
  localparam int CFG_W_BIT  = 1;
  localparam int CFG_X_BIT  = 2;
  localparam int CFG_A_LSB  = 3;
  localparam int CFG_A_MSB  = 4;
  localparam int CFG_L_BIT  = 7;

  typedef enum logic [1:0] {
    A_OFF   = 2'b00,
    A_TOR   = 2'b01,
    A_NA4   = 2'b10,
    A_NAPOT = 2'b11
  } pmp_a_e;

  typedef struct packed {
    logic       l;
    logic [1:0] rsvd;
    pmp_a_e     a;
    logic       x;
    logic       w;
    logic       r;
  } pmp_cfg_t;

  // Locked bytes never change; W=1/R=0 is an illegal combination, so the old byte stays.
  function automatic pmp_cfg_t cfg_legalize(input pmp_cfg_t old_cfg, input logic [7:0] wdata);
    pmp_cfg_t new_cfg;
    new_cfg      = pmp_cfg_t'(wdata);
    new_cfg.rsvd = 2'b00;
    if (old_cfg.l || (new_cfg.w && !new_cfg.r)) begin
      return old_cfg;
    end
    return new_cfg;
  endfunction

endpackage

// File: rtl/pmp_csr_regfile_napot_mask_gen.sv
// NAPOT don't-care mask for one entry: the trailing-ones run of pmpaddr plus
// the two implicit byte-offset bits, truncated to the decoded address width.
module pmp_napot_mask_gen #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [31:0]           pmpaddr,
  output logic [ADDR_WIDTH-1:0] mask
);

  assign mask = ADDR_WIDTH'({pmpaddr ^ (pmpaddr + 32'd1), 2'b11});

endmodule

// File: rtl/pmp_csr_regfile.sv
// Architectural PMP CSRs (pmpcfg/pmpaddr, RV32) with a one-cycle CSR response
// and registered per-entry decode (byte address, previous address, NAPOT mask).
module pmp_csr_regfile
  import pmp_csr_regfile_pkg::*;
#(
  parameter int PMP_ENTRIES = 16,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   csr_req_vld,
  output logic                                   csr_req_rdy,
  input  logic                                   csr_req_wr,
  input  logic [11:0]                            csr_req_addr,
  input  logic [31:0]                            csr_req_wdata,
  output logic                                   csr_rsp_vld,
  output logic                                   csr_rsp_hit,
  output logic [31:0]                            csr_rsp_rdata,
  output logic [PMP_ENTRIES-1:0][7:0]            pmp_cfg,
  output logic [PMP_ENTRIES-1:0][ADDR_WIDTH-1:0] pmp_addr,
  output logic [PMP_ENTRIES-1:0][ADDR_WIDTH-1:0] pmp_addr_last,
  output logic [PMP_ENTRIES-1:0][ADDR_WIDTH-1:0] pmp_napot_mask,
  output logic                                   pmp_stale
);

  pmp_cfg_t [PMP_ENTRIES-1:0]                  cfg_reg, cfg_next;
  logic     [PMP_ENTRIES-1:0][31:0]            addr_reg, addr_next;
  logic     [PMP_ENTRIES-1:0][ADDR_WIDTH-1:0]  mask_reg, mask_comb;
  logic     [PMP_ENTRIES-1:0]                  addr_locked;
  logic                                        rsp_vld_reg, rsp_hit_reg, stale_reg;
  logic     [31:0]                             rsp_rdata_reg, rdata_next;
  logic     [11:0]                             cfg_off, addr_off;
  logic                                        cfg_hit, addr_hit, accept, do_wr;

  assign csr_req_rdy = ~stale_reg;
  assign accept      = csr_req_vld & csr_req_rdy;
  assign do_wr       = accept & csr_req_wr;
  assign cfg_off     = csr_req_addr - PMPCFG0;
  assign addr_off    = csr_req_addr - PMPADDR0;
  assign cfg_hit     = cfg_off < 12'(PMP_ENTRIES / 4);
  assign addr_hit    = addr_off < 12'(PMP_ENTRIES);

  // A TOR entry that is locked also freezes the address below it.
  genvar gi;
  generate
    for (gi = 0; gi < PMP_ENTRIES; gi++) begin : g_entry
      if (gi == PMP_ENTRIES - 1) begin : g_top
        assign addr_locked[gi] = cfg_reg[gi].l;
      end else begin : g_mid
        assign addr_locked[gi] = cfg_reg[gi].l | (cfg_reg[gi+1].l & (cfg_reg[gi+1].a == A_TOR));
      end

      if (gi == 0) begin : g_first
        assign pmp_addr_last[gi] = '0;
      end else begin : g_rest
        assign pmp_addr_last[gi] = pmp_addr[gi-1];
      end

      assign pmp_cfg[gi]        = cfg_reg[gi];
      assign pmp_addr[gi]       = ADDR_WIDTH'({addr_reg[gi], 2'b00});
      assign pmp_napot_mask[gi] = mask_reg[gi];

      pmp_napot_mask_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_mask (
        .pmpaddr (addr_reg[gi]),
        .mask    (mask_comb[gi])
      );
    end
  endgenerate

  always_comb begin
    cfg_next   = cfg_reg;
    addr_next  = addr_reg;
    rdata_next = '0;
    for (int e = 0; e < PMP_ENTRIES; e++) begin
      if (do_wr && cfg_hit && (cfg_off == 12'(e / 4))) begin
        cfg_next[e] = cfg_legalize(cfg_reg[e], csr_req_wdata[8*(e%4) +: 8]);
      end
      if (do_wr && addr_hit && (addr_off == 12'(e)) && !addr_locked[e]) begin
        addr_next[e] = csr_req_wdata;
      end
    end
    // Read data reflects the post-write state so writes echo what stuck.
    for (int e = 0; e < PMP_ENTRIES; e++) begin
      if (cfg_hit && (cfg_off == 12'(e / 4))) begin
        rdata_next[8*(e%4) +: 8] = cfg_next[e];
      end
      if (addr_hit && (addr_off == 12'(e))) begin
        rdata_next = addr_next[e];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_reg       <= '0;
      addr_reg      <= '0;
      mask_reg      <= '0;
      rsp_vld_reg   <= 1'b0;
      rsp_hit_reg   <= 1'b0;
      rsp_rdata_reg <= '0;
      stale_reg     <= 1'b0;
    end else begin
      cfg_reg       <= cfg_next;
      addr_reg      <= addr_next;
      rsp_vld_reg   <= accept;
      rsp_hit_reg   <= accept & (cfg_hit | addr_hit);
      rsp_rdata_reg <= accept ? rdata_next : 32'd0;
      stale_reg     <= do_wr;
      if (stale_reg) begin
        mask_reg <= mask_comb;
      end
    end
  end

  assign csr_rsp_vld   = rsp_vld_reg;
  assign csr_rsp_hit   = rsp_hit_reg;
  assign csr_rsp_rdata = rsp_rdata_reg;
  assign pmp_stale     = stale_reg;

endmodule

// File: tb/tb_pmp_csr_regfile.sv
// Directed bench for pmp_csr_regfile: CSR accesses with hand-computed
// responses and decoded-output checks, one line per transaction.
module tb_pmp_csr_regfile;

  localparam int E  = 16;
  localparam int AW = 32;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 csr_req_vld = 1'b0;
  logic                 csr_req_rdy;
  logic                 csr_req_wr = 1'b0;
  logic [11:0]          csr_req_addr = '0;
  logic [31:0]          csr_req_wdata = '0;
  logic                 csr_rsp_vld;
  logic                 csr_rsp_hit;
  logic [31:0]          csr_rsp_rdata;
  logic [E-1:0][7:0]    pmp_cfg;
  logic [E-1:0][AW-1:0] pmp_addr;
  logic [E-1:0][AW-1:0] pmp_addr_last;
  logic [E-1:0][AW-1:0] pmp_napot_mask;
  logic                 pmp_stale;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pmp_csr_regfile #(.PMP_ENTRIES(E), .ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .csr_req_vld    (csr_req_vld),
    .csr_req_rdy    (csr_req_rdy),
    .csr_req_wr     (csr_req_wr),
    .csr_req_addr   (csr_req_addr),
    .csr_req_wdata  (csr_req_wdata),
    .csr_rsp_vld    (csr_rsp_vld),
    .csr_rsp_hit    (csr_rsp_hit),
    .csr_rsp_rdata  (csr_rsp_rdata),
    .pmp_cfg        (pmp_cfg),
    .pmp_addr       (pmp_addr),
    .pmp_addr_last  (pmp_addr_last),
    .pmp_napot_mask (pmp_napot_mask),
    .pmp_stale      (pmp_stale)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one access from a negedge; returns at the negedge of the response cycle.
  task automatic issue(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                       input logic exp_hit, input logic [31:0] exp_rdata, input string tag);
    int waited = 0;
    while (!csr_req_rdy && waited < 4) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_rdy"}, 64'(csr_req_rdy), 64'd1);
    csr_req_vld   = 1'b1;
    csr_req_wr    = wr;
    csr_req_addr  = addr;
    csr_req_wdata = wdata;
    @(posedge clk);
    #1 csr_req_vld = 1'b0;
    @(negedge clk);
    $display("%s %s addr=%h wdata=%h -> vld=%0b hit=%0b rdata=%h stale=%0b",
             tag, wr ? "WR" : "RD", addr, wdata, csr_rsp_vld, csr_rsp_hit, csr_rsp_rdata, pmp_stale);
    check({tag, "_rsp_vld"}, 64'(csr_rsp_vld), 64'd1);
    check({tag, "_hit"}, 64'(csr_rsp_hit), 64'(exp_hit));
    check({tag, "_rdata"}, 64'(csr_rsp_rdata), 64'(exp_rdata));
    check({tag, "_stale"}, 64'(pmp_stale), 64'(wr));
    check({tag, "_bubble_rdy"}, 64'(csr_req_rdy), 64'(!wr));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_rdy", 64'(csr_req_rdy), 64'd1);
    check("reset_rsp_vld", 64'(csr_rsp_vld), 64'd0);
    check("reset_hit", 64'(csr_rsp_hit), 64'd0);
    check("reset_rdata", 64'(csr_rsp_rdata), 64'd0);
    check("reset_stale", 64'(pmp_stale), 64'd0);
    check("reset_cfg", 64'(|pmp_cfg), 64'd0);
    check("reset_addr", 64'(|pmp_addr), 64'd0);
    check("reset_mask", 64'(|pmp_napot_mask), 64'd0);

    issue(1'b0, 12'h3B5, 32'h0, 1'b1, 32'h0, "rd_addr5");
    @(negedge clk);
    check("rsp_vld_pulse", 64'(csr_rsp_vld), 64'd0);

    issue(1'b1, 12'h3B2, 32'h0000_0107, 1'b1, 32'h0000_0107, "wr_addr2");
    check("addr2_at_write", 64'(pmp_addr[2]), 64'h41C);
    check("mask2_still_old", 64'(pmp_napot_mask[2]), 64'h0);
    @(negedge clk);
    check("stale_cleared", 64'(pmp_stale), 64'd0);
    check("mask2", 64'(pmp_napot_mask[2]), 64'h3F);
    check("addr_last3", 64'(pmp_addr_last[3]), 64'h41C);
    check("addr_last0", 64'(pmp_addr_last[0]), 64'h0);

    issue(1'b1, 12'h3A0, 32'h0018_0000, 1'b1, 32'h0018_0000, "wr_cfg_napot");
    @(negedge clk);
    check("cfg2_napot", 64'(pmp_cfg[2]), 64'h18);

    issue(1'b1, 12'h3A0, 32'h0018_0200, 1'b1, 32'h0018_0000, "wr_cfg_w_no_r");
    @(negedge clk);
    check("cfg1_warl", 64'(pmp_cfg[1]), 64'h00);

    issue(1'b1, 12'h3A0, 32'h0018_E300, 1'b1, 32'h0018_8300, "wr_cfg_lock");
    @(negedge clk);
    check("cfg1_locked", 64'(pmp_cfg[1]), 64'h83);

    issue(1'b1, 12'h3A0, 32'h0018_0000, 1'b1, 32'h0018_8300, "wr_cfg_locked");
    @(negedge clk);
    check("cfg1_still", 64'(pmp_cfg[1]), 64'h83);

    issue(1'b1, 12'h3B1, 32'h0000_1234, 1'b1, 32'h0, "wr_addr1_locked");
    @(negedge clk);
    check("addr1_unchanged", 64'(pmp_addr[1]), 64'h0);

    issue(1'b1, 12'h3A0, 32'h8818_8300, 1'b1, 32'h8818_8300, "wr_cfg3_tor");
    @(negedge clk);
    check("cfg3_tor", 64'(pmp_cfg[3]), 64'h88);

    issue(1'b1, 12'h3B2, 32'h0000_ABCD, 1'b1, 32'h0000_0107, "wr_addr2_tor_locked");
    @(negedge clk);
    check("addr2_kept", 64'(pmp_addr[2]), 64'h41C);
    check("addr_last3_kept", 64'(pmp_addr_last[3]), 64'h41C);

    issue(1'b1, 12'h3B0, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, "wr_addr0_ones");
    check("addr0_ones", 64'(pmp_addr[0]), 64'hFFFF_FFFC);
    @(negedge clk);
    check("mask0_ones", 64'(pmp_napot_mask[0]), 64'hFFFF_FFFF);
    check("addr_last1", 64'(pmp_addr_last[1]), 64'hFFFF_FFFC);

    issue(1'b0, 12'h7C0, 32'h0, 1'b0, 32'h0, "rd_unmapped");
    @(negedge clk);
    issue(1'b1, 12'h7C0, 32'hFFFF_FFFF, 1'b0, 32'h0, "wr_unmapped");
    @(negedge clk);
    check("unmapped_cfg2", 64'(pmp_cfg[2]), 64'h18);
    check("unmapped_addr0", 64'(pmp_addr[0]), 64'hFFFF_FFFC);

    issue(1'b0, 12'h3A4, 32'h0, 1'b0, 32'h0, "rd_cfg_past_end");
    @(negedge clk);
    issue(1'b0, 12'h3C0, 32'h0, 1'b0, 32'h0, "rd_addr_past_end");
    @(negedge clk);
    issue(1'b0, 12'h3BF, 32'h0, 1'b1, 32'h0, "rd_addr15");
    @(negedge clk);
    issue(1'b0, 12'h3A0, 32'h0, 1'b1, 32'h8818_8300, "rd_cfg0");
    @(negedge clk);
    issue(1'b0, 12'h3B2, 32'h0, 1'b1, 32'h0000_0107, "rd_addr2");
    @(negedge clk);

    issue(1'b1, 12'h3B4, 32'h0000_0055, 1'b1, 32'h0000_0055, "wr_before_reset");
    rst = 1'b1;
    @(negedge clk);
    $display("reset_mid_op stale=%0b rsp_vld=%0b rdy=%0b", pmp_stale, csr_rsp_vld, csr_req_rdy);
    check("rst_stale", 64'(pmp_stale), 64'd0);
    check("rst_rsp_vld", 64'(csr_rsp_vld), 64'd0);
    check("rst_rdy", 64'(csr_req_rdy), 64'd1);
    check("rst_rdata", 64'(csr_rsp_rdata), 64'd0);
    check("rst_cfg", 64'(|pmp_cfg), 64'd0);
    check("rst_addr", 64'(|pmp_addr), 64'd0);
    check("rst_mask", 64'(|pmp_napot_mask), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pmp_csr_regfile.md
Name: pmp_csr_regfile

Overview:
- Owns the architectural PMP CSRs: pmpcfg0..3 and pmpaddr0..15 for RV32.
- Serves CSR reads and writes from the core's CSR unit over a valid/ready request and response pair.
- Drives the per-entry decoded values that each PMP address-check instance consumes: A field, byte address, previous-entry byte address and NAPOT mask.
- Masks are precomputed in a registered stage, so the address check stays purely combinational.

Parameters:
- PMP_ENTRIES, 16, number of PMP entries; must be a multiple of 4 and at most 16.
- ADDR_WIDTH, 32, byte-address width of the decoded outputs; must be at most 34.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- csr_req_vld  in  1  CSR access request
- csr_req_rdy  out  1  regfile can accept a request this cycle
- csr_req_wr  in  1  1 = write, 0 = read
- csr_req_addr  in  12  CSR address
- csr_req_wdata  in  32  write data
- csr_rsp_vld  out  1  response valid, exactly 1 cycle after acceptance
- csr_rsp_hit  out  1  address decoded to an implemented PMP CSR
- csr_rsp_rdata  out  32  read data (also returned for writes: the post-write value)
- pmp_cfg  out  PMP_ENTRIES x 8  raw cfg bytes {L,00,A[1:0],X,W,R}
- pmp_addr  out  PMP_ENTRIES x ADDR_WIDTH  byte address = pmpaddr<<2, truncated to ADDR_WIDTH
- pmp_addr_last  out  PMP_ENTRIES x ADDR_WIDTH  pmp_addr of entry i-1; entry 0 drives 0
- pmp_napot_mask  out  PMP_ENTRIES x ADDR_WIDTH  NAPOT don't-care mask
- pmp_stale  out  1  decoded outputs do not yet reflect the last write

Behaviour:
- Reset: all cfg bytes 0 (A=OFF, L=0), all pmpaddr 0, all masks 0. csr_req_rdy=1, csr_rsp_vld=0, csr_rsp_hit=0, csr_rsp_rdata=0, pmp_stale=0.
- Accept condition: a request is accepted when csr_req_vld & csr_req_rdy; state is updated at that clock edge.
- Response timing: csr_rsp_vld pulses 1 in the following cycle together with rsp_hit and rsp_rdata. There is no response backpressure.
- Address decode:
  - 0x3A0..0x3A0+PMP_ENTRIES/4-1 → pmpcfg word k, holding entries 4k..4k+3, byte j = entry 4k+j.
  - 0x3B0..0x3B0+PMP_ENTRIES-1 → pmpaddr i.
  - Anything else → hit=0, rdata=0, no state change.
- pmpaddr storage: 32 bits; the stored value represents byte address bits [33:2].
- Write rules, per cfg byte:
  - Ignored if the existing L=1.
  - Bits [6:5] are forced to 0.
  - If the new W=1 and R=0, the whole byte keeps its old value (WARL).
- Write rules, pmpaddr i: ignored if cfg[i].L=1, or if cfg[i+1].L=1 and cfg[i+1].A=TOR.
- Read rules: return the stored value. Reserved bits read 0.
- Mask stage:
  - Computed one cycle after an accepted write: mask[i] = {(pmpaddr[i] ^ (pmpaddr[i]+1)), 2'b11}, truncated to ADDR_WIDTH.
  - Example: pmpaddr = 0x...07 gives mask 0x3F.
  - All-ones pmpaddr gives an all-ones mask (wrap of +1).
- Stale window:
  - pmp_cfg, pmp_addr and pmp_addr_last update at the write edge.
  - pmp_napot_mask updates one edge later.
  - pmp_stale=1 for exactly the cycle between those edges.
  - csr_req_rdy=0 during that cycle, so back-to-back writes are spaced by 1 bubble. Reads are never stalled by reads.
- Write to an unimplemented or locked target: the response is still produced, with hit=1 when the address decodes, and the rdata shows the unchanged value. Stale is still asserted for 1 cycle, which keeps the timing uniform.
- Reset mid-operation: reset dominates. A pending response and the stale flag clear, and no partial write is retained.
- L bit: L is only cleared by reset.

Decomposition:
- toy_pack additions:
  - CSR address constants PMPCFG0=12'h3A0 and PMPADDR0=12'h3B0.
  - cfg bit-position localparams.
  - A-field encodings, reusing OFF/TOR/NA4/NAPOT.
  - A pmp_cfg_t packed struct {L, rsvd[1:0], A[1:0], X, W, R}.
- Sub-module pmp_napot_mask_gen: combinational, one per entry, pmpaddr → mask. It is instantiated inside the registered mask stage.

Test Plan:
- Reset → all pmp_cfg=0, pmp_addr=0, masks=0, rdy=1. Read 0x3B5 → rsp_vld next cycle, hit=1, rdata=0.
- Write 0x3B2=0x0000_0107, then 0x3A0=0x0018_0000 (entry 2 A=NAPOT, R=W=X=0) → pmp_addr[2]=0x41C. pmp_stale=1 for one cycle after the first write, then pmp_napot_mask[2]=0x3F. rdy=0 in the bubble cycle.
- Write 0x3A0 with byte1=0x02 (W=1, R=0) → the byte keeps its old value. Write byte1=0xE3 → stored 0x83 (bits 6:5 cleared, L set). A later write of 0x00 → still 0x83. Write 0x3B1 → ignored.
- Entry 3 cfg=0x88 (L=1, TOR) → a write to 0x3B2 is ignored, and pmp_addr_last[3] equals pmp_addr[2] unchanged.
- Write pmpaddr0=0xFFFF_FFFF → mask[0]=all-ones, pmp_addr[0]=0xFFFF_FFFC. Access to 0x7C0 → hit=0, rdata=0, no state change.
- Assert rst while pmp_stale=1 → next cycle all outputs are at reset values and rsp_vld=0.
